// File: rtl/mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_unit
// Description : Store-side memory formatter for the RISC-V core. Accepts one
//               SB/SH/SW request per transaction and turns it into one or two
//               word-aligned write beats (lane-shifted data plus byte-enable)
//               on a valid/ready write port. A one-cycle done pulse (with err)
//               closes every transaction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ALLOW_MISALIGNED : 1 = split word-crossing stores into two beats,
//                      0 = reject them with err and write nothing.
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   store request present
//   req_ready  out  1   idle, request can be accepted
//   req_addr   in  32   byte address
//   req_func3  in   3   000 SB, 001 SH, 010 SW, others illegal
//   req_data   in  32   store data (rs2), right-aligned
//   mem_valid  out  1   write beat present
//   mem_ready  in   1   memory accepts the beat
//   mem_addr   out 32   word-aligned beat address
//   mem_wdata  out 32   lane-shifted write data
//   mem_we     out  4   byte enables, bit i = byte lane i
//   done       out  1   one-cycle completion pulse
//   err        out  1   qualified by done: request rejected, nothing written
// ============================================================================
module mem_store_unit #(
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state;

  // Second-beat fields, captured at accept time so that beat 1 can be
  // presented on the cycle right after the beat-0 handshake.
  logic [31:0] b1_addr;
  logic [31:0] b1_wdata;
  logic [3:0]  b1_we;
  logic        crossing;

  // --------------------------------------------------------------------------
  // Beat formatting, evaluated on the request inputs and captured at accept.
  // --------------------------------------------------------------------------
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic        legal;
  logic [63:0] sh64;
  logic [7:0]  m8;
  logic        word_cross;
  logic        reject;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;

  always_comb begin
    off       = req_addr[1:0];
    size_mask = 4'b0000;
    legal     = 1'b1;
    case (req_func3)
      3'b000:  size_mask = 4'b0001;
      3'b001:  size_mask = 4'b0011;
      3'b010:  size_mask = 4'b1111;
      default: legal     = 1'b0;
    endcase
    // Byte offset times 8 is the bit shift; the upper half of sh64 and m8
    // holds whatever spills into the following word.
    sh64       = {32'h0000_0000, req_data} << {off, 3'b000};
    m8         = {4'b0000, size_mask} << off;
    word_cross = |m8[7:4];
    reject     = !legal || (word_cross && (ALLOW_MISALIGNED == 0));
    beat0_addr = {req_addr[31:2], 2'b00};
    beat1_addr = beat0_addr + 32'd4;   // wraps modulo 2^32
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_we    <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      b1_addr   <= 32'h0000_0000;
      b1_wdata  <= 32'h0000_0000;
      b1_we     <= 4'b0000;
      crossing  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            b1_addr   <= beat1_addr;
            b1_wdata  <= sh64[63:32];
            b1_we     <= m8[7:4];
            crossing  <= word_cross;
            if (reject) begin
              // No beat at all: report straight away.
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_RESP;
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= beat0_addr;
              mem_wdata <= sh64[31:0];
              mem_we    <= m8[3:0];
              state     <= S_BEAT0;
            end
          end
        end

        S_BEAT0: begin
          if (mem_ready) begin
            if (crossing) begin
              // mem_valid stays high; swap in the second-word beat.
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              mem_we    <= b1_we;
              state     <= S_BEAT1;
            end else begin
              mem_valid <= 1'b0;
              mem_we    <= 4'b0000;
              done      <= 1'b1;
              err       <= 1'b0;
              state     <= S_RESP;
            end
          end
        end

        S_BEAT1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 4'b0000;
            done      <= 1'b1;
            err       <= 1'b0;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
          mem_we    <= 4'b0000;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_unit
// Description : Self-checking bench for mem_store_unit. Two instances share
//               the stimulus: one splits word-crossing stores, one rejects
//               them. Table-driven transactions plus a hand-written
//               mid-operation reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [31:0] req_data;
  logic        mem_ready;

  logic        a_req_ready, a_mem_valid, a_done, a_err;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_we;
  logic        b_req_ready, b_mem_valid, b_done, b_err;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_we;

  // sel chooses which instance is observed: 0 = split, 1 = reject.
  logic        sel = 1'b0;
  logic        v_req_ready, v_mem_valid, v_done, v_err;
  logic [31:0] v_mem_addr, v_mem_wdata;
  logic [3:0]  v_mem_we;

  assign v_req_ready = sel ? b_req_ready : a_req_ready;
  assign v_mem_valid = sel ? b_mem_valid : a_mem_valid;
  assign v_done      = sel ? b_done      : a_done;
  assign v_err       = sel ? b_err       : a_err;
  assign v_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign v_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign v_mem_we    = sel ? b_mem_we    : a_mem_we;

  always #5 clk = ~clk;

  mem_store_unit #(.ALLOW_MISALIGNED(1)) dut_split (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_func3(req_func3), .req_data(req_data),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .done(a_done), .err(a_err)
  );

  mem_store_unit #(.ALLOW_MISALIGNED(0)) dut_reject (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_func3(req_func3), .req_data(req_data),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .done(b_done), .err(b_err)
  );

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
    int          stall;   // cycles mem_ready is held low on each beat
    int          nb;      // expected number of beats
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic        err;
    int          dcyc;    // sample index (cycles after accept) of done
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !(a_req_ready && b_req_ready); i++) step();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ba [2];
    logic [3:0]  bw [2];
    logic [31:0] bd [2];
    logic [31:0] ha, hd;
    logic [3:0]  hw;
    logic        held, got_err;
    int          nb, dc, wait_cnt, unstable;
    bit          fin;
    nb = 0; dc = 0; wait_cnt = 0; unstable = 0; held = 1'b0; got_err = 1'b0; fin = 1'b0;
    ha = '0; hd = '0; hw = '0;
    for (int i = 0; i < 2; i++) begin ba[i] = '0; bw[i] = '0; bd[i] = '0; end
    sel = v.sel;
    mem_ready = 1'b1;
    wait_idle();
    chk($sformatf("%s.req_ready", tag), {31'b0, v_req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_func3 = v.f3; req_data = v.data;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      if (v_done) begin
        fin = 1'b1; dc = k; got_err = v_err;
        chk($sformatf("%s.we_at_done", tag), {28'b0, v_mem_we}, 32'd0);
      end else begin
        if (v_mem_valid) begin
          if (!held) begin
            held = 1'b1; ha = v_mem_addr; hd = v_mem_wdata; hw = v_mem_we; wait_cnt = 0;
          end else if (v_mem_addr !== ha || v_mem_wdata !== hd || v_mem_we !== hw) begin
            unstable++;
          end
          if (wait_cnt < v.stall) begin
            mem_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_ready = 1'b1;
            if (nb < 2) begin ba[nb] = ha; bw[nb] = hw; bd[nb] = hd; end
            nb++;
            held = 1'b0;
          end
        end else begin
          mem_ready = 1'b1;
        end
        step();
      end
    end
    mem_ready = 1'b1;
    chk($sformatf("%s.done_seen", tag), {31'b0, fin}, 32'd1);
    chk($sformatf("%s.done_cycle", tag), dc, v.dcyc);
    chk($sformatf("%s.err", tag), {31'b0, got_err}, {31'b0, v.err});
    chk($sformatf("%s.beats", tag), nb, v.nb);
    chk($sformatf("%s.stable", tag), unstable, 32'd0);
    if (v.nb >= 1) begin
      chk($sformatf("%s.b0_addr", tag), ba[0], v.a0);
      chk($sformatf("%s.b0_we", tag), {28'b0, bw[0]}, {28'b0, v.we0});
      chk($sformatf("%s.b0_wdata", tag), bd[0], v.wd0);
    end
    if (v.nb >= 2) begin
      chk($sformatf("%s.b1_addr", tag), ba[1], v.a1);
      chk($sformatf("%s.b1_we", tag), {28'b0, bw[1]}, {28'b0, v.we1});
      chk($sformatf("%s.b1_wdata", tag), bd[1], v.wd1);
    end
    step();
    chk($sformatf("%s.done_pulse", tag), {31'b0, v_done}, 32'd0);
    chk($sformatf("%s.ready_after", tag), {31'b0, v_req_ready}, 32'd1);
  endtask

  vec_t vecs [11];

  initial begin
    int bad;
    vecs[0]  = '{0, 32'h0000_1003, 3'b000, 32'hAABB_CCDD, 0, 1, 32'h0000_1000, 4'b1000, 32'hDD00_0000, 32'h0, 4'h0, 32'h0, 1'b0, 2};
    vecs[1]  = '{0, 32'h0000_2002, 3'b001, 32'h0000_1234, 0, 1, 32'h0000_2000, 4'b1100, 32'h1234_0000, 32'h0, 4'h0, 32'h0, 1'b0, 2};
    vecs[2]  = '{0, 32'h0000_3001, 3'b010, 32'h1122_3344, 0, 2, 32'h0000_3000, 4'b1110, 32'h2233_4400, 32'h0000_3004, 4'b0001, 32'h0000_0011, 1'b0, 3};
    vecs[3]  = '{0, 32'h0000_3FFF, 3'b001, 32'h0000_BEEF, 3, 2, 32'h0000_3FFC, 4'b1000, 32'hEF00_0000, 32'h0000_4000, 4'b0001, 32'h0000_00BE, 1'b0, 9};
    vecs[4]  = '{0, 32'h0000_5000, 3'b010, 32'hCAFE_F00D, 0, 1, 32'h0000_5000, 4'b1111, 32'hCAFE_F00D, 32'h0, 4'h0, 32'h0, 1'b0, 2};
    vecs[5]  = '{0, 32'h0000_0010, 3'b000, 32'h0000_00A5, 0, 1, 32'h0000_0010, 4'b0001, 32'h0000_00A5, 32'h0, 4'h0, 32'h0, 1'b0, 2};
    vecs[6]  = '{0, 32'hFFFF_FFFF, 3'b010, 32'h1122_3344, 0, 2, 32'hFFFF_FFFC, 4'b1000, 32'h4400_0000, 32'h0000_0000, 4'b0111, 32'h0011_2233, 1'b0, 3};
    vecs[7]  = '{0, 32'h0000_3000, 3'b011, 32'h1234_5678, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1};
    vecs[8]  = '{0, 32'h0000_4000, 3'b111, 32'h1234_5678, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1};
    vecs[9]  = '{1, 32'h0000_3001, 3'b010, 32'h1122_3344, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1};
    vecs[10] = '{1, 32'h0000_2002, 3'b001, 32'h0000_1234, 0, 1, 32'h0000_2000, 4'b1100, 32'h1234_0000, 32'h0, 4'h0, 32'h0, 1'b0, 2};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_func3 = '0; req_data = '0; mem_ready = 1'b0;
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk($sformatf("reset%0d.req_ready", s), {31'b0, v_req_ready}, 32'd1);
      chk($sformatf("reset%0d.mem_valid", s), {31'b0, v_mem_valid}, 32'd0);
      chk($sformatf("reset%0d.mem_we", s), {28'b0, v_mem_we}, 32'd0);
      chk($sformatf("reset%0d.done", s), {31'b0, v_done}, 32'd0);
      chk($sformatf("reset%0d.err", s), {31'b0, v_err}, 32'd0);
      chk($sformatf("reset%0d.mem_addr", s), v_mem_addr, 32'd0);
      chk($sformatf("reset%0d.mem_wdata", s), v_mem_wdata, 32'd0);
    end
    rst = 1'b0;
    sel = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while beat 1 of a split store is pending.
    sel = 1'b0;
    mem_ready = 1'b1;
    wait_idle();
    req_valid = 1'b1; req_addr = 32'h0000_3001; req_func3 = 3'b010; req_data = 32'h1122_3344;
    step();
    req_valid = 1'b0;
    chk("rstmid.beat0_valid", {31'b0, v_mem_valid}, 32'd1);
    chk("rstmid.beat0_addr", v_mem_addr, 32'h0000_3000);
    step();
    chk("rstmid.beat1_addr", v_mem_addr, 32'h0000_3004);
    chk("rstmid.beat1_we", {28'b0, v_mem_we}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid.req_ready", {31'b0, v_req_ready}, 32'd1);
    chk("rstmid.mem_valid", {31'b0, v_mem_valid}, 32'd0);
    chk("rstmid.mem_we", {28'b0, v_mem_we}, 32'd0);
    chk("rstmid.done", {31'b0, v_done}, 32'd0);
    chk("rstmid.mem_addr", v_mem_addr, 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (v_mem_valid || v_done) bad++;
    end
    chk("rstmid.quiet", bad, 32'd0);
    run_vec('{0, 32'h0000_6000, 3'b010, 32'h0BAD_CAFE, 0, 1, 32'h0000_6000, 4'b1111, 32'h0BAD_CAFE, 32'h0, 4'h0, 32'h0, 1'b0, 2}, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
